// File: rtl/vec_wb_collector_pkg.sv
// Shared vector-unit definitions: writeback FSM encoding, SEW codes,
// default register width and lane geometry constants (also used by the
// ALU wrapper upstream of the collector).
package vec_wb_collector_pkg;

    // Writeback collector FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2
    } vec_state_e;

    // Element width codes: SEW = 8 << vsew.
    localparam logic [2:0] SEW_8  = 3'd0;
    localparam logic [2:0] SEW_16 = 3'd1;
    localparam logic [2:0] SEW_32 = 3'd2;
    localparam logic [2:0] SEW_64 = 3'd3;

    localparam int VLEN_DEFAULT = 128;
    // Every lane occupies a 64-bit data slot and a 10-bit index slot.
    localparam int LANE_SLOT_W  = 64;
    localparam int IDX_W        = 10;
    // Chunk widths range 8..64, so 7 bits are enough.
    localparam int CHUNK_W_BITS = 7;

    // Chunk width actually merged: the element width, capped by the lane
    // chunk width. Reserved vsew codes above 64-bit clamp to 64.
    function automatic logic [CHUNK_W_BITS-1:0] chunk_width(
        input logic [2:0] vsew,
        input int         lane_width
    );
        logic [CHUNK_W_BITS-1:0] sew_bits;
        logic [CHUNK_W_BITS-1:0] lane_bits;
        sew_bits  = (vsew >= SEW_64) ? 7'd64 : (7'd8 << vsew);
        lane_bits = CHUNK_W_BITS'(1 << lane_width);
        return (sew_bits < lane_bits) ? sew_bits : lane_bits;
    endfunction

endpackage

// File: rtl/vec_chunk_merge.sv
// One lane's merge stage: writes the low `width` bits of `data` into the
// accumulator at bit offset `idx`. A chunk that would run past the top of
// the vector is dropped whole and flagged through range_err.
module vec_chunk_merge
    import vec_wb_collector_pkg::*;
#(
    parameter int VLEN = VLEN_DEFAULT
) (
    input  logic [VLEN-1:0]         acc_in,
    input  logic                    en,
    input  logic [LANE_SLOT_W-1:0]  data,
    input  logic [IDX_W-1:0]        idx,
    input  logic [CHUNK_W_BITS-1:0] width,
    output logic [VLEN-1:0]         acc_out,
    output logic                    range_err
);

    logic [IDX_W:0]           end_bit;
    logic [LANE_SLOT_W-1:0]   low_mask;
    logic [VLEN-1:0]          mask_sh;
    logic [VLEN-1:0]          data_sh;

    // Build the shifted field mask, range-check, and splice the chunk in.
    always_comb begin
        end_bit   = {1'b0, idx} + (IDX_W+1)'(width);
        low_mask  = (width >= 7'd64) ? '1 : ((64'd1 << width) - 64'd1);
        mask_sh   = VLEN'(low_mask) << idx;
        data_sh   = VLEN'(data & low_mask) << idx;
        range_err = en && (end_bit > (IDX_W+1)'(VLEN));
        acc_out   = acc_in;
        if (en && !range_err) begin
            acc_out = (acc_in & ~mask_sh) | data_sh;
        end
    end

endmodule

// File: rtl/vec_wb_collector.sv
// Vector writeback collector: gathers per-lane result chunks from the ALU
// wrapper into a VLEN-bit accumulator, then hands the full destination
// vector to the register file. One instruction in flight at a time.
//
// Optional feature macro: VEC_WB_TAIL_UNDISTURBED_EN. When defined, an
// old_vd input seeds the accumulator on start so unwritten elements keep
// their previous register content; otherwise the accumulator starts at 0.
//
// Handshake: wb_valid rises in WRITE and stays high with wb_data/wb_addr
// stable until the cycle wb_ready is also high; that cycle is the transfer,
// done pulses combinationally with it and the FSM returns to IDLE next edge.
module vec_wb_collector
    import vec_wb_collector_pkg::*;
#(
    parameter int VLEN       = VLEN_DEFAULT,
    parameter int LANE_WIDTH = 3,
    parameter int NB_LANES   = 1,
    localparam int LANES     = 1 << NB_LANES
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           start,
    input  logic [4:0]                     vd_addr,
    input  logic [2:0]                     vsew,
`ifdef VEC_WB_TAIL_UNDISTURBED_EN
    input  logic [VLEN-1:0]                old_vd,
`endif
    input  logic [LANE_SLOT_W*LANES-1:0]   lane_data,
    input  logic [IDX_W*LANES-1:0]         lane_idx,
    input  logic [LANES-1:0]               lane_valid,
    input  logic                           alu_done,
    output logic                           wb_valid,
    input  logic                           wb_ready,
    output logic [4:0]                     wb_addr,
    output logic [VLEN-1:0]                wb_data,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [1:0]                     dbg_state
);

    vec_state_e              state_q;
    vec_state_e              state_d;
    logic [4:0]              addr_q;
    logic [2:0]              sew_q;
    logic [VLEN-1:0]         acc_q;
    logic                    err_q;
    logic [VLEN-1:0]         acc_init;
    logic [VLEN-1:0]         merged_acc;
    logic [LANES-1:0]        lane_err;
    logic [CHUNK_W_BITS-1:0] chunk_w;

`ifdef VEC_WB_TAIL_UNDISTURBED_EN
    assign acc_init = old_vd;
`else
    assign acc_init = '0;
`endif

    assign chunk_w = chunk_width(sew_q, LANE_WIDTH);

    // Lane-ordered merge chain: a later lane overwrites earlier lanes where
    // their fields overlap, so the highest-numbered lane wins.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [VLEN-1:0] acc_in_w;
        logic [VLEN-1:0] acc_out_w;
        if (g == 0) begin : g_first
            assign acc_in_w = acc_q;
        end else begin : g_next
            assign acc_in_w = g_lane[g-1].acc_out_w;
        end
        vec_chunk_merge #(
            .VLEN (VLEN)
        ) u_merge (
            .acc_in    (acc_in_w),
            .en        (lane_valid[g]),
            .data      (lane_data[LANE_SLOT_W*g +: LANE_SLOT_W]),
            .idx       (lane_idx[IDX_W*g +: IDX_W]),
            .width     (chunk_w),
            .acc_out   (acc_out_w),
            .range_err (lane_err[g])
        );
    end

    assign merged_acc = g_lane[LANES-1].acc_out_w;

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start)    state_d = ST_COLLECT;
            ST_COLLECT: if (alu_done) state_d = ST_WRITE;
            ST_WRITE:   if (wb_ready) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: writeback request, busy and the handshake pulse.
    always_comb begin
        wb_valid = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_COLLECT: begin
                busy = 1'b1;
            end
            ST_WRITE: begin
                busy     = 1'b1;
                wb_valid = 1'b1;
                done     = wb_ready;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Instruction context and accumulator: latch on start, merge while
    // collecting, hold through WRITE so the writeback payload is stable.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_q <= '0;
            sew_q  <= SEW_8;
            acc_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q <= vd_addr;
                        sew_q  <= vsew;
                        acc_q  <= acc_init;
                        err_q  <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    acc_q <= merged_acc;
                    if (|lane_err) begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    acc_q <= acc_q;
                end
            endcase
        end
    end

    assign wb_data   = acc_q;
    assign wb_addr   = addr_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vec_wb_collector.sv
// Bench for vec_wb_collector: directed scenarios with literal expectations
// plus randomized instructions, all checked every cycle against a
// bit-level behavioural model of the collector.
module tb_vec_wb_collector;

    localparam int VLEN  = 128;
    localparam int LW    = 3;
    localparam int NB    = 1;
    localparam int LANES = 1 << NB;

    logic                   clk;
    logic                   resetn;
    logic                   start;
    logic [4:0]             vd_addr;
    logic [2:0]             vsew;
    logic [VLEN-1:0]        old_vd;
    logic [64*LANES-1:0]    lane_data;
    logic [10*LANES-1:0]    lane_idx;
    logic [LANES-1:0]       lane_valid;
    logic                   alu_done;
    logic                   wb_valid;
    logic                   wb_ready;
    logic [4:0]             wb_addr;
    logic [VLEN-1:0]        wb_data;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [1:0]             dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 0;

    vec_wb_collector #(
        .VLEN       (VLEN),
        .LANE_WIDTH (LW),
        .NB_LANES   (NB)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .vd_addr    (vd_addr),
        .vsew       (vsew),
`ifdef VEC_WB_TAIL_UNDISTURBED_EN
        .old_vd     (old_vd),
`endif
        .lane_data  (lane_data),
        .lane_idx   (lane_idx),
        .lane_valid (lane_valid),
        .alu_done   (alu_done),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_phase: 0 waiting for an instruction, 1 gathering chunks, 2 offering
    // the vector to the register file.
    int              m_phase = 0;
    logic [VLEN-1:0] m_acc   = '0;
    logic [4:0]      m_addr  = '0;
    logic [2:0]      m_sew   = '0;
    logic            m_err   = 1'b0;

    always @(posedge clk) begin : model
        int w;
        int ix;
        int sew_bits;
        if (!resetn) begin
            m_phase = 0;
            m_acc   = '0;
            m_addr  = '0;
            m_sew   = '0;
            m_err   = 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase = 1;
                m_addr  = vd_addr;
                m_sew   = vsew;
                m_err   = 1'b0;
`ifdef VEC_WB_TAIL_UNDISTURBED_EN
                m_acc   = old_vd;
`else
                m_acc   = '0;
`endif
            end
        end else if (m_phase == 1) begin
            sew_bits = 8 << m_sew;
            w = (sew_bits < (1 << LW)) ? sew_bits : (1 << LW);
            for (int l = 0; l < LANES; l++) begin
                if (lane_valid[l]) begin
                    ix = int'(lane_idx[10*l +: 10]);
                    if (ix + w > VLEN) begin
                        m_err = 1'b1;
                    end else begin
                        for (int b = 0; b < w; b++) begin
                            m_acc[ix+b] = lane_data[64*l+b];
                        end
                    end
                end
            end
            if (alu_done) m_phase = 2;
        end else begin
            if (wb_ready) m_phase = 0;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [VLEN-1:0] got,
                         input logic [VLEN-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", VLEN'(busy), VLEN'(m_phase != 0));
            check("wb_valid", VLEN'(wb_valid), VLEN'(m_phase == 2));
            check("done", VLEN'(done), VLEN'((m_phase == 2) && wb_ready));
            check("err", VLEN'(err), VLEN'(m_err));
            if (m_phase == 2) begin
                check("wb_addr", VLEN'(wb_addr), VLEN'(m_addr));
                check("wb_data", wb_data, m_acc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        lane_valid = '0;
        alu_done   = 1'b0;
        lane_data  = '0;
        lane_idx   = '0;
    endtask

    task automatic set_lane(input int l, input logic [63:0] d, input logic [9:0] ix);
        lane_valid[l]          = 1'b1;
        lane_data[64*l +: 64]  = d;
        lane_idx[10*l +: 10]   = ix;
    endtask

    task automatic do_start(input logic [4:0] a, input logic [2:0] s);
        start   = 1'b1;
        vd_addr = a;
        vsew    = s;
        tick();
        start   = 1'b0;
    endtask

    // Hold ready low for `delay` cycles, then complete the handshake.
    task automatic wait_wb(input int delay);
        int n;
        n = 0;
        wb_ready = 1'b0;
        repeat (delay) tick();
        wb_ready = 1'b1;
        while (!(wb_valid && wb_ready)) begin
            if (n > 50) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wb_timeout: got no wb_valid within 50 cycles, required a writeback");
                break;
            end
            tick();
            n++;
        end
        tick();
        wb_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [VLEN-1:0] lit;
        int beats;
        resetn   = 1'b0;
        start    = 1'b0;
        vd_addr  = '0;
        vsew     = '0;
        old_vd   = '0;
        wb_ready = 1'b0;
        clear_lanes();

        // Reset state.
        repeat (3) tick();
        cmp_en = 1;
        check("rst_busy", VLEN'(busy), '0);
        check("rst_wb_valid", VLEN'(wb_valid), '0);
        check("rst_wb_addr", VLEN'(wb_addr), '0);
        check("rst_acc", wb_data, '0);
        check("rst_err", VLEN'(err), '0);
        check("rst_done", VLEN'(done), '0);
        resetn = 1'b1;
        tick();

        // 1: two lanes of bytes fill the vector with 0..15 ascending.
        do_start(5'd5, 3'd0);
        for (int k = 0; k < 8; k++) begin
            clear_lanes();
            set_lane(0, 64'(2*k), 10'(16*k));
            set_lane(1, 64'(2*k+1), 10'(16*k+8));
            alu_done = (k == 7);
            tick();
        end
        clear_lanes();
        lit = 128'h0F0E0D0C0B0A09080706050403020100;
        check("t1_data", wb_data, lit);
        check("t1_model", m_acc, lit);
        check("t1_addr", VLEN'(wb_addr), VLEN'(5'd5));
        check("t1_valid", VLEN'(wb_valid), VLEN'(1'b1));
        wait_wb(0);

        // 2: SEW32 element assembled from four byte chunks.
        do_start(5'd3, 3'd2);
        for (int k = 0; k < 4; k++) begin
            clear_lanes();
            set_lane(0, 64'(8'hAA + 8'h11*k), 10'(8*k));
            alu_done = (k == 3);
            if (k == 3) check("t2_not_yet_valid", VLEN'(wb_valid), '0);
            tick();
        end
        clear_lanes();
        check("t2_valid_next", VLEN'(wb_valid), VLEN'(1'b1));
        check("t2_data", wb_data, VLEN'(32'hDDCCBBAA));
        wait_wb(2);

        // 3: backpressure with an ignored start during WRITE.
        do_start(5'd9, 3'd0);
        set_lane(0, 64'h5A, 10'd40);
        alu_done = 1'b1;
        tick();
        clear_lanes();
        lit = VLEN'(8'h5A) << 40;
        wb_ready = 1'b0;
        start    = 1'b1;
        vd_addr  = 5'd1;
        repeat (5) begin
            check("t3_hold_data", wb_data, lit);
            check("t3_hold_addr", VLEN'(wb_addr), VLEN'(5'd9));
            tick();
        end
        start    = 1'b0;
        wb_ready = 1'b1;
        #1;
        check("t3_done", VLEN'(done), VLEN'(1'b1));
        tick();
        wb_ready = 1'b0;
        check("t3_busy_after", VLEN'(busy), '0);
        check("t3_done_after", VLEN'(done), '0);

        // 4: out-of-range chunk dropped, other lane merged, err cleared on start.
        do_start(5'd2, 3'd0);
        set_lane(0, 64'h55, 10'd124);
        set_lane(1, 64'h66, 10'd0);
        alu_done = 1'b1;
        tick();
        clear_lanes();
        check("t4_err", VLEN'(err), VLEN'(1'b1));
        check("t4_data", wb_data, VLEN'(8'h66));
        wait_wb(0);
        check("t4_err_sticky", VLEN'(err), VLEN'(1'b1));
        do_start(5'd2, 3'd0);
        check("t4_err_cleared", VLEN'(err), '0);
        alu_done = 1'b1;
        tick();
        clear_lanes();
        wait_wb(0);

        // 5: overlapping chunks in one cycle, higher lane wins.
        do_start(5'd7, 3'd0);
        set_lane(0, 64'h11, 10'd0);
        set_lane(1, 64'h22, 10'd0);
        alu_done = 1'b1;
        tick();
        clear_lanes();
        check("t5_data", wb_data, VLEN'(8'h22));
        wait_wb(1);

        // 6: reset during COLLECT aborts, then init value behaviour.
        do_start(5'd4, 3'd0);
        set_lane(0, 64'h77, 10'd0);
        tick();
        clear_lanes();
        resetn = 1'b0;
        tick();
        check("t6_busy", VLEN'(busy), '0);
        check("t6_valid", VLEN'(wb_valid), '0);
        check("t6_err", VLEN'(err), '0);
        resetn = 1'b1;
        tick();
`ifdef VEC_WB_TAIL_UNDISTURBED_EN
        old_vd = '1;
        do_start(5'd4, 3'd0);
        set_lane(0, 64'h00, 10'd0);
        lit = '1;
        lit[7:0] = 8'h00;
`else
        do_start(5'd4, 3'd0);
        set_lane(0, 64'hAB, 10'd8);
        lit = VLEN'(16'hAB00);
`endif
        alu_done = 1'b1;
        tick();
        clear_lanes();
        check("t6_data", wb_data, lit);
        wait_wb(0);

        // Randomized instructions with stray activity outside COLLECT.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                set_lane(0, {$urandom, $urandom}, 10'($urandom_range(0, 120)));
                alu_done = 1'b1;
                tick();
                clear_lanes();
            end
            old_vd = {$urandom, $urandom, $urandom, $urandom};
            do_start(5'($urandom_range(0, 31)), 3'($urandom_range(0, 3)));
            beats = $urandom_range(1, 6);
            for (int b = 0; b < beats; b++) begin
                clear_lanes();
                for (int l = 0; l < LANES; l++) begin
                    if ($urandom_range(0, 3) != 0) begin
                        if ($urandom_range(0, 7) == 0)
                            set_lane(l, {$urandom, $urandom}, 10'($urandom_range(0, 1023)));
                        else
                            set_lane(l, {$urandom, $urandom}, 10'($urandom_range(0, VLEN + 8)));
                    end
                end
                alu_done = (b == beats - 1);
                tick();
            end
            clear_lanes();
            if ($urandom_range(0, 1) == 1) begin
                set_lane(1, {$urandom, $urandom}, 10'($urandom_range(0, 120)));
                alu_done = 1'b1;
            end
            wait_wb($urandom_range(0, 3));
            clear_lanes();
        end

        repeat (2) tick();
        cmp_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
